icache_dataram_rd_sched: RTL
============================

Name: icache_dataram_rd_sched

Overview:
Scheduler for the single icache dataram read port. Two kinds of requester share it: the pipeline hit-path read, and up to ENTRY_NUM MSHR entries that read back a filled line. The hit path has fixed priority, MSHR entries are served round-robin, and a starvation counter forces MSHR service. Output is a one-entry registered slice in front of the dataram.

Parameters:
ENTRY_NUM, 4, number of MSHR read requesters
ENTRY_ID_WIDTH, 2, log2(ENTRY_NUM)
INDEX_WIDTH, 6, dataram set-index width
TXNID_WIDTH, 8, transaction id width
STARVE_MAX, 8, consecutive hit grants tolerated while any MSHR request waits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
hit_rd_vld  in  1  hit-path read request
hit_rd_rdy  out  1  hit-path request accepted this cycle
hit_rd_way  in  1  way select
hit_rd_index  in  INDEX_WIDTH  set index
hit_rd_txnid  in  TXNID_WIDTH  txn id
v_mshr_rd_vld  in  ENTRY_NUM  per-entry read request
v_mshr_rd_rdy  out  ENTRY_NUM  per-entry accept, one-hot or zero
v_mshr_rd_way  in  ENTRY_NUM  per-entry way
v_mshr_rd_index  in  ENTRY_NUM*INDEX_WIDTH  packed; entry i at [i*INDEX_WIDTH +: INDEX_WIDTH]
v_mshr_rd_txnid  in  ENTRY_NUM*TXNID_WIDTH  packed, same layout
dataram_rd_vld  out  1  registered read request to dataram
dataram_rd_rdy  in  1  dataram accepts
dataram_rd_way  out  1  way
dataram_rd_index  out  INDEX_WIDTH  index
dataram_rd_txnid  out  TXNID_WIDTH  txn id
dataram_rd_src  out  1  0 = hit path, 1 = MSHR
dataram_rd_entry_id  out  ENTRY_ID_WIDTH  MSHR entry id; 0 when src=0
hit_grant_cnt  out  16  perf counter (see Optional Feature)
mshr_grant_cnt  out  16  perf counter (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high. All state is sampled on posedge clk.
- Reset values: dataram_rd_vld=0; payload, src and entry_id = 0; rr_ptr = ENTRY_NUM-1, so entry 0 is searched first; starve_cnt = 0; both perf counters = 0. Reset mid-transfer drops the held request with no completion.
- Output slice:
  - load_en = !dataram_rd_vld | dataram_rd_rdy.
  - The slot holds its payload stable while vld=1 and rdy=0.
  - Latency: accept in cycle N gives dataram_rd_vld in cycle N+1.
  - Back-to-back accepts give one grant per cycle.
- Arbitration (combinational, qualified by load_en):
  - mshr_any = |v_mshr_rd_vld.
  - The RR winner is the first set bit of v_mshr_rd_vld searching from rr_ptr+1, wrapping at ENTRY_NUM-1 to 0.
  - force_mshr = mshr_any & (starve_cnt == STARVE_MAX).
  - If hit_rd_vld & !force_mshr: hit_rd_rdy = load_en and v_mshr_rd_rdy = 0.
  - Otherwise, if mshr_any: v_mshr_rd_rdy[winner] = load_en and hit_rd_rdy = 0.
  - rdy is never asserted to a requester whose vld is low. It never depends on the current cycle's dataram_rd_rdy other than through load_en.
- Slot load on accept:
  - Selected way/index/txnid are written to the slot.
  - src is 1 for an MSHR grant. entry_id is the winner on an MSHR grant, else 0.
  - dataram_rd_vld is set. With load_en=1 and no request, dataram_rd_vld clears.
- rr_ptr updates to the winner only on an accepted MSHR grant.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on an accepted hit grant while mshr_any=1.
  - Clears on an accepted MSHR grant, or in any cycle with mshr_any=0.
  - Holds otherwise, including stall cycles with load_en=0.
- Simultaneous events: hit and MSHR requests in the same cycle are resolved by priority and starvation only. Release of the slot and a new accept in the same cycle is legal (slot drains and refills).
- Request stability: requesters keep vld and payload stable until rdy. The scheduler does not check this.

Optional Feature:
Macro ICACHE_RD_SCHED_PERF_EN.
- Defined: hit_grant_cnt and mshr_grant_cnt count accepted hit and MSHR grants. Each is 16-bit, saturating at 16'hFFFF, and cleared by rst.
- Not defined: both ports are tied to 0 and no counter flops exist. Scheduling behaviour is identical either way.

Test Plan:
- Reset, then hit_rd_vld=1 with index=6'h15 and dataram_rd_rdy=1 -> hit_rd_rdy=1 in cycle 0; next cycle dataram_rd_vld=1, index=6'h15, src=0.
- v_mshr_rd_vld=4'b1111 held, no hit, rdy=1 -> grants go to entries 0,1,2,3,0 on consecutive cycles; entry_id follows the same order.
- hit_rd_vld=1 continuously, v_mshr_rd_vld=4'b0100, STARVE_MAX=8 -> 8 hit grants, then the 9th accepted grant goes to entry 2; starve_cnt returns to 0, and the hit is granted on the next cycle.
- Slot full with dataram_rd_rdy=0 for 3 cycles and requests pending -> all rdy outputs 0, payload stable, starve_cnt unchanged; when rdy=1, drain and refill occur in the same cycle.
- rst asserted while dataram_rd_vld=1 and the slot is stalled -> next cycle vld=0, rr_ptr reset, so entry 0 is granted first afterwards.
- With ICACHE_RD_SCHED_PERF_EN: 5 hit grants and 3 MSHR grants -> hit_grant_cnt=5, mshr_grant_cnt=3. Without the macro: both read 0.

Source files
------------

// File: rtl/icache_dataram_rd_sched_if.sv
// Request/accept bundle around the icache dataram read scheduler: hit-path and MSHR
// requesters on one side, the dataram read port and grant counters on the other.
interface icache_dataram_rd_sched_if #(
  parameter int ENTRY_NUM      = 4,
  parameter int ENTRY_ID_WIDTH = 2,
  parameter int INDEX_WIDTH    = 6,
  parameter int TXNID_WIDTH    = 8
);
  logic                            hit_rd_vld;
  logic                            hit_rd_rdy;
  logic                            hit_rd_way;
  logic [INDEX_WIDTH-1:0]          hit_rd_index;
  logic [TXNID_WIDTH-1:0]          hit_rd_txnid;

  logic [ENTRY_NUM-1:0]            v_mshr_rd_vld;
  logic [ENTRY_NUM-1:0]            v_mshr_rd_rdy;
  logic [ENTRY_NUM-1:0]            v_mshr_rd_way;
  logic [ENTRY_NUM*INDEX_WIDTH-1:0] v_mshr_rd_index;
  logic [ENTRY_NUM*TXNID_WIDTH-1:0] v_mshr_rd_txnid;

  logic                            dataram_rd_vld;
  logic                            dataram_rd_rdy;
  logic                            dataram_rd_way;
  logic [INDEX_WIDTH-1:0]          dataram_rd_index;
  logic [TXNID_WIDTH-1:0]          dataram_rd_txnid;
  logic                            dataram_rd_src;
  logic [ENTRY_ID_WIDTH-1:0]       dataram_rd_entry_id;

  logic [15:0]                     hit_grant_cnt;
  logic [15:0]                     mshr_grant_cnt;

  modport master (
    output hit_rd_vld, hit_rd_way, hit_rd_index, hit_rd_txnid,
    output v_mshr_rd_vld, v_mshr_rd_way, v_mshr_rd_index, v_mshr_rd_txnid,
    output dataram_rd_rdy,
    input  hit_rd_rdy, v_mshr_rd_rdy,
    input  dataram_rd_vld, dataram_rd_way, dataram_rd_index, dataram_rd_txnid,
    input  dataram_rd_src, dataram_rd_entry_id,
    input  hit_grant_cnt, mshr_grant_cnt
  );

  modport slave (
    input  hit_rd_vld, hit_rd_way, hit_rd_index, hit_rd_txnid,
    input  v_mshr_rd_vld, v_mshr_rd_way, v_mshr_rd_index, v_mshr_rd_txnid,
    input  dataram_rd_rdy,
    output hit_rd_rdy, v_mshr_rd_rdy,
    output dataram_rd_vld, dataram_rd_way, dataram_rd_index, dataram_rd_txnid,
    output dataram_rd_src, dataram_rd_entry_id,
    output hit_grant_cnt, mshr_grant_cnt
  );
endinterface

// File: rtl/icache_dataram_rd_sched.sv
// Dataram read-port scheduler: hit path first, MSHR entries round-robin, starvation forces MSHR.
// Latency 1 cycle (accept in N, dataram_rd_vld in N+1); one-entry slot, no accept while it is stalled.
// ICACHE_RD_SCHED_PERF_EN adds saturating hit/MSHR grant counters; otherwise they read 0.
module icache_dataram_rd_sched #(
  parameter int ENTRY_NUM      = 4,
  parameter int ENTRY_ID_WIDTH = 2,
  parameter int INDEX_WIDTH    = 6,
  parameter int TXNID_WIDTH    = 8,
  parameter int STARVE_MAX     = 8
) (
  input logic                      clk,
  input logic                      rst,
  icache_dataram_rd_sched_if.slave rd_if
);
  localparam int STARVE_WIDTH = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic                      way;
    logic [INDEX_WIDTH-1:0]    index;
    logic [TXNID_WIDTH-1:0]    txnid;
    logic                      src;
    logic [ENTRY_ID_WIDTH-1:0] entry_id;
  } rd_req_t;

  rd_req_t                   slot_dat;
  logic                      slot_vld;
  logic [ENTRY_ID_WIDTH-1:0] rr_ptr;
  logic [STARVE_WIDTH-1:0]   starve_cnt;

  logic [INDEX_WIDTH-1:0]    mshr_index [ENTRY_NUM];
  logic [TXNID_WIDTH-1:0]    mshr_txnid [ENTRY_NUM];

  for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_unpack
    assign mshr_index[gi] = rd_if.v_mshr_rd_index[gi*INDEX_WIDTH +: INDEX_WIDTH];
    assign mshr_txnid[gi] = rd_if.v_mshr_rd_txnid[gi*TXNID_WIDTH +: TXNID_WIDTH];
  end

  // Walk from the entry after rr_ptr, wrapping, and keep the first requester found.
  logic [ENTRY_ID_WIDTH-1:0] rr_win;
  logic [ENTRY_ID_WIDTH-1:0] rr_cand;
  logic                      rr_found;
  always_comb begin
    rr_win   = rr_ptr;
    rr_cand  = rr_ptr;
    rr_found = 1'b0;
    for (int k = 0; k < ENTRY_NUM; k++) begin
      rr_cand = (rr_cand == ENTRY_ID_WIDTH'(ENTRY_NUM - 1)) ? '0 : rr_cand + 1'b1;
      if (!rr_found && rd_if.v_mshr_rd_vld[rr_cand]) begin
        rr_found = 1'b1;
        rr_win   = rr_cand;
      end
    end
  end

  logic load_en, mshr_any, force_mshr, hit_sel, mshr_sel, hit_acc, mshr_acc;
  assign load_en    = !slot_vld || rd_if.dataram_rd_rdy;
  assign mshr_any   = |rd_if.v_mshr_rd_vld;
  assign force_mshr = mshr_any && (starve_cnt == STARVE_WIDTH'(STARVE_MAX));
  assign hit_sel    = rd_if.hit_rd_vld && !force_mshr;
  assign mshr_sel   = !hit_sel && mshr_any;
  assign hit_acc    = hit_sel && load_en;
  assign mshr_acc   = mshr_sel && load_en;

  assign rd_if.hit_rd_rdy    = hit_acc;
  assign rd_if.v_mshr_rd_rdy = mshr_acc ? (ENTRY_NUM'(1) << rr_win) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld   <= 1'b0;
      slot_dat   <= '0;
      rr_ptr     <= ENTRY_ID_WIDTH'(ENTRY_NUM - 1);
      starve_cnt <= '0;
    end else begin
      if (load_en) slot_vld <= hit_acc || mshr_acc;
      if (hit_acc) begin
        slot_dat <= '{way: rd_if.hit_rd_way, index: rd_if.hit_rd_index,
                      txnid: rd_if.hit_rd_txnid, src: 1'b0,
                      entry_id: {ENTRY_ID_WIDTH{1'b0}}};
      end else if (mshr_acc) begin
        slot_dat <= '{way: rd_if.v_mshr_rd_way[rr_win], index: mshr_index[rr_win],
                      txnid: mshr_txnid[rr_win], src: 1'b1, entry_id: rr_win};
        rr_ptr   <= rr_win;
      end
      // Stall cycles leave the counter untouched: no grant happened either way.
      if (!mshr_any || mshr_acc) starve_cnt <= '0;
      else if (hit_acc && (starve_cnt != STARVE_WIDTH'(STARVE_MAX))) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign rd_if.dataram_rd_vld      = slot_vld;
  assign rd_if.dataram_rd_way      = slot_dat.way;
  assign rd_if.dataram_rd_index    = slot_dat.index;
  assign rd_if.dataram_rd_txnid    = slot_dat.txnid;
  assign rd_if.dataram_rd_src      = slot_dat.src;
  assign rd_if.dataram_rd_entry_id = slot_dat.entry_id;

`ifdef ICACHE_RD_SCHED_PERF_EN
  logic [15:0] hit_grant_q;
  logic [15:0] mshr_grant_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_grant_q  <= '0;
      mshr_grant_q <= '0;
    end else begin
      if (hit_acc && (hit_grant_q != 16'hFFFF))   hit_grant_q  <= hit_grant_q + 16'd1;
      if (mshr_acc && (mshr_grant_q != 16'hFFFF)) mshr_grant_q <= mshr_grant_q + 16'd1;
    end
  end
  assign rd_if.hit_grant_cnt  = hit_grant_q;
  assign rd_if.mshr_grant_cnt = mshr_grant_q;
`else
  assign rd_if.hit_grant_cnt  = '0;
  assign rd_if.mshr_grant_cnt = '0;
`endif
endmodule
